// File: rtl/ana_pad_switch_seq.sv
// ana_pad_switch_seq: break-before-make sequencer for one-hot analog pad switch enables.
// Optional clamp_en output is enabled by defining ANA_SW_CLAMP_EN.
module ana_pad_switch_seq #(
  parameter int CHANNELS      = 4,
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8,
  localparam int SEL_W        = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic                req_off,
  output logic [CHANNELS-1:0] sw_en,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                settled,
  output logic                busy,
  output logic                err
`ifdef ANA_SW_CLAMP_EN
  , output logic              clamp_en
`endif
);
  localparam int MAX_IV = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] DEAD_M1   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   CH_N      = (SEL_W + 1)'(CHANNELS);
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be in 2..16");
  end
  if (DEAD_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_interval
    $error("DEAD_CYCLES and SETTLE_CYCLES must be >= 1");
  end
  if ((2 ** CNT_W) - 1 < MAX_IV) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEAD_CYCLES/SETTLE_CYCLES");
  end
  typedef enum logic [1:0] {IDLE, BREAK, MAKE, ON} state_t;
  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [SEL_W-1:0]    r_sel, w_sel_nx;
  logic                r_off, w_off_nx;
  logic                w_acc, w_oor, w_nop, w_err_nx;
  logic [CHANNELS-1:0] w_dec;
  logic [CHANNELS-1:0] r_sw_en;
  logic                r_settled, r_busy, r_err;
  assign req_ready = (r_state == IDLE) || (r_state == ON);
  assign sw_en     = r_sw_en;
  assign cur_sel   = r_sel;
  assign settled   = r_settled;
  assign busy      = r_busy;
  assign err       = r_err;
  assign w_dec     = {{(CHANNELS-1){1'b0}}, 1'b1} << w_sel_nx;
  always_comb begin
    w_acc      = req_valid && req_ready;
    w_oor      = !req_off && ({1'b0, req_sel} >= CH_N);
    w_nop      = w_oor || (req_off && r_state == IDLE) ||
                 (!req_off && r_state == ON && req_sel == r_sel);
    w_err_nx   = w_acc && w_oor;
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_sel;
    w_off_nx   = r_off;
    if (w_acc && !w_nop) begin
      w_state_nx = BREAK;
      w_cnt_nx   = DEAD_M1;
      w_off_nx   = req_off;
      w_sel_nx   = req_off ? r_sel : req_sel;
    end else if (r_state == BREAK) begin
      w_state_nx = (r_cnt != '0) ? BREAK : (r_off ? IDLE : MAKE);
      w_cnt_nx   = (r_cnt != '0) ? r_cnt - 1'b1 : SETTLE_M1;
    end else if (r_state == MAKE) begin
      w_state_nx = (r_cnt != '0) ? MAKE : ON;
      w_cnt_nx   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    end
  end
`ifdef ANA_SW_CLAMP_EN
  logic r_clamp;
  assign clamp_en = r_clamp;
`endif
  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_off     <= 1'b0;
      r_sw_en   <= '0;
      r_settled <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
`ifdef ANA_SW_CLAMP_EN
      r_clamp   <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_sel     <= w_sel_nx;
      r_off     <= w_off_nx;
      r_sw_en   <= (w_state_nx == MAKE || w_state_nx == ON) ? w_dec : '0;
      r_settled <= w_state_nx == ON;
      r_busy    <= w_state_nx == BREAK || w_state_nx == MAKE;
      r_err     <= w_err_nx;
`ifdef ANA_SW_CLAMP_EN
      r_clamp   <= w_state_nx == IDLE || w_state_nx == BREAK;
`endif
    end
  end
endmodule

// File: tb/tb_ana_pad_switch_seq.sv
// tb_ana_pad_switch_seq: scoreboard bench; expected per-cycle outputs queued at request time.
module tb_ana_pad_switch_seq;
  localparam int D = 4;
  localparam int S = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       req_valid = 1'b0, req_ready, req_off = 1'b0, settled, busy, err;
  logic [1:0] req_sel = '0, cur_sel;
  logic [3:0] sw_en;
`ifdef ANA_SW_CLAMP_EN
  logic clamp_en, clamp3;
`endif
  logic       v3 = 1'b0, o3 = 1'b0, rdy3, st3, bz3, err3;
  logic [1:0] s3 = '0, cs3;
  logic [2:0] sw3;
  ana_pad_switch_seq #(.CHANNELS(4), .DEAD_CYCLES(D), .SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_off(req_off), .sw_en(sw_en), .cur_sel(cur_sel), .settled(settled), .busy(busy), .err(err)
`ifdef ANA_SW_CLAMP_EN
    , .clamp_en(clamp_en)
`endif
  );
  ana_pad_switch_seq #(.CHANNELS(3), .DEAD_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_sel(s3),
    .req_off(o3), .sw_en(sw3), .cur_sel(cs3), .settled(st3), .busy(bz3), .err(err3)
`ifdef ANA_SW_CLAMP_EN
    , .clamp_en(clamp3)
`endif
  );
  typedef struct {int cyc; logic [3:0] sw; logic st; logic bz; logic rdy; logic [1:0] cs;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0;
  logic [1:0] m_cur = '0;
  bit m_on = 1'b0;
  logic [3:0] last_nz = '0;
  int zrun = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int c, input logic [3:0] sw, input logic st, input logic bz,
                      input logic rdy, input logic [1:0] cs);
    exp_t t;
    t = '{c, sw, st, bz, rdy, cs};
    q.push_back(t);
  endtask
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, x);
    end
  endfunction
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed cyc=%0d now=%0d", e.cyc, cyc);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if ({sw_en, settled, busy, req_ready, cur_sel, err} !== {e.sw, e.st, e.bz, e.rdy, e.cs, 1'b0}) begin
        failures++;
        $display("FAIL out cyc=%0d sw=%b st=%b bz=%b rdy=%b cs=%0d err=%b expected sw=%b st=%b bz=%b rdy=%b cs=%0d err=0",
                 cyc, sw_en, settled, busy, req_ready, cur_sel, err, e.sw, e.st, e.bz, e.rdy, e.cs);
      end
    end
    if (!$onehot0(sw_en)) begin
      checks++;
      failures++;
      $display("FAIL multihot cyc=%0d sw=%b expected onehot0", cyc, sw_en);
    end
    if (sw_en == 4'b0) zrun++;
    else begin
      if (last_nz != 4'b0 && sw_en != last_nz) begin
        checks++;
        if (zrun < D) begin
          failures++;
          $display("FAIL deadtime cyc=%0d zeros=%0d required>=%0d", cyc, zrun, D);
        end
      end
      zrun = 0;
      last_nz = sw_en;
    end
`ifdef ANA_SW_CLAMP_EN
    if (!rst) chk("clamp", 32'(clamp_en), 32'(sw_en == 4'b0));
`endif
  end
  task automatic req(input logic [1:0] sel, input logic off, output int acc);
    int n = 0;
    logic [1:0] tgt;
    logic [3:0] oh;
    @(negedge clk);
    req_sel = sel;
    req_off = off;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_timeout ready=0 expected 1");
    end
    acc = cyc;
    tgt = off ? m_cur : sel;
    oh = 4'b0001 << tgt;
    if (off && !m_on) push(acc + 1, 4'b0, 1'b0, 1'b0, 1'b1, m_cur);
    else if (!off && m_on && sel == m_cur) push(acc + 1, oh, 1'b1, 1'b0, 1'b1, m_cur);
    else begin
      for (int c = 1; c <= D; c++) push(acc + c, 4'b0, 1'b0, 1'b1, 1'b0, tgt);
      if (off) push(acc + D + 1, 4'b0, 1'b0, 1'b0, 1'b1, tgt);
      else begin
        for (int c = D + 1; c <= D + S; c++) push(acc + c, oh, 1'b0, 1'b1, 1'b0, tgt);
        push(acc + D + S + 1, oh, 1'b1, 1'b0, 1'b1, tgt);
      end
      m_on = !off;
      m_cur = tgt;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    q.delete();
    rst = 1'b1;
    push(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    m_on = 1'b0;
    m_cur = '0;
  endtask
  initial begin
    int a1, a2, n;
    do_reset();
    req(2'd2, 1'b0, a1);
    req(2'd1, 1'b0, a2);
    chk("held_accept_gap", 32'(a2 - a1), 32'(D + S + 1));
    req(2'd1, 1'b0, a1);
    req(2'd0, 1'b1, a1);
    req(2'd3, 1'b1, a1);
    req(2'd3, 1'b0, a1);
    repeat (D + 3) @(negedge clk);
    do_reset();
    for (int i = 0; i < 30; i++)
      req(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), a1);
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd3; o3 = 1'b0;
    @(posedge clk); #1 v3 = 1'b0;
    chk("oor_err", 32'(err3), 32'd1);
    chk("oor_sw", 32'(sw3), 32'd0);
    chk("oor_cs", 32'(cs3), 32'd0);
    chk("oor_rdy", 32'(rdy3), 32'd1);
    @(posedge clk); #1;
    chk("err_pulse_end", 32'(err3), 32'd0);
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd2;
    @(posedge clk); #1 v3 = 1'b0;
    chk("c3_break_busy", 32'(bz3), 32'd1);
    chk("c3_break_sw", 32'(sw3), 32'd0);
    @(posedge clk); #1;
    chk("c3_make_sw", 32'(sw3), 32'b100);
    chk("c3_make_st", 32'(st3), 32'd0);
    @(posedge clk); #1;
    chk("c3_on_st", 32'(st3), 32'd1);
    chk("c3_on_busy", 32'(bz3), 32'd0);
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd3;
    @(posedge clk); #1 v3 = 1'b0;
    chk("on_oor_err", 32'(err3), 32'd1);
    chk("on_oor_sw", 32'(sw3), 32'b100);
    chk("on_oor_cs", 32'(cs3), 32'd2);
    chk("on_oor_st", 32'(st3), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
